// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response channel and the data-memory port.
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both 1. req_ready is 1 only while the unit is idle and out of reset, so at
// most one request is in flight. The requester may drop req_valid right after
// the transfer. resp_valid is a one-cycle pulse with no back-pressure. The memory
// side has no handshake: a write happens on every edge where mem_byte_enable is
// non-zero, and mem_read_data follows mem_address combinationally.
// The master modport is the requester plus memory; the slave modport is the unit.
`timescale 1ns/1ps
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address,
               req_write_data, mem_read_data,
        input  req_ready, resp_valid, resp_read_data, resp_error,
               mem_address, mem_byte_enable, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address,
               req_write_data, mem_read_data,
        output req_ready, resp_valid, resp_read_data, resp_error,
               mem_address, mem_byte_enable, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns MEM-stage requests into one or two word accesses on a
// sync-write / comb-read data memory, and aligns/extends load results.
`timescale 1ns/1ps
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic        r_error;

    logic        w_ready;
    logic        w_accept;
    logic        w_req_cross;
    logic        w_req_error;
    logic [1:0]  w_off;
    logic        w_cross;
    logic [7:0]  w_lane_mask;
    logic [5:0]  w_sh_lo;
    logic [5:0]  w_sh_hi;
    logic [31:0] w_word_addr;
    logic [31:0] w_load_raw;
    logic [31:0] w_load_ext;

    // Access width in bytes; size 3 is illegal and never reaches an access state.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Byte mask of the access before it is shifted into lane position.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    assign w_ready     = (r_state == S_IDLE) && !rst;
    assign w_accept    = bus.req_valid && w_ready;
    assign w_req_cross = ({1'b0, bus.req_address[1:0]} + size_bytes(bus.req_size)) > 3'd4;
    assign w_req_error = (bus.req_size == 2'd3) || (!ALLOW_MISALIGNED && w_req_cross);
    assign o_dbg_state = r_state;

    // Geometry of the latched request: lane offset, word crossing, shifts.
    always_comb begin
        w_off       = r_addr[1:0];
        w_cross     = ({1'b0, w_off} + size_bytes(r_size)) > 3'd4;
        w_lane_mask = {4'b0000, size_mask(r_size)} << w_off;
        w_sh_lo     = {1'b0, w_off, 3'b000};
        w_sh_hi     = 6'd32 - w_sh_lo;
        w_word_addr = {r_addr[31:2], 2'b00};
    end

    // Load alignment: bytes from lo starting at off, topped up from hi when crossing.
    always_comb begin
        w_load_raw = (r_lo >> w_sh_lo) | (r_hi << w_sh_hi);
        case (r_size)
            2'd0:    w_load_ext = r_unsigned ? {24'd0, w_load_raw[7:0]}
                                             : {{24{w_load_raw[7]}}, w_load_raw[7:0]};
            2'd1:    w_load_ext = r_unsigned ? {16'd0, w_load_raw[15:0]}
                                             : {{16{w_load_raw[15]}}, w_load_raw[15:0]};
            default: w_load_ext = w_load_raw;
        endcase
    end

    // Next state and all bus outputs; everything is held at zero during reset.
    always_comb begin
        w_next                 = r_state;
        bus.req_ready          = w_ready;
        bus.resp_valid         = 1'b0;
        bus.resp_error         = 1'b0;
        bus.resp_read_data     = 32'd0;
        bus.mem_address        = 32'd0;
        bus.mem_byte_enable    = 4'd0;
        bus.mem_write_data     = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_req_error ? S_RESP : S_ACC0;
                end
            end
            S_ACC0: begin
                w_next = w_cross ? S_ACC1 : S_RESP;
                if (!rst) begin
                    bus.mem_address = w_word_addr;
                    if (r_write) begin
                        bus.mem_byte_enable = w_lane_mask[3:0];
                        bus.mem_write_data  = r_wdata << w_sh_lo;
                    end
                end
            end
            S_ACC1: begin
                w_next = S_RESP;
                if (!rst) begin
                    bus.mem_address = w_word_addr + 32'd4;
                    if (r_write) begin
                        bus.mem_byte_enable = w_lane_mask[7:4];
                        bus.mem_write_data  = r_wdata >> w_sh_hi;
                    end
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
                if (!rst) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_error = r_error;
                    if (!r_error && !r_write) begin
                        bus.resp_read_data = w_load_ext;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch on accept and load-word capture during the access states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_lo       <= 32'd0;
            r_hi       <= 32'd0;
            r_error    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write    <= bus.req_write;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_addr     <= bus.req_address;
                r_wdata    <= bus.req_write_data;
                r_error    <= w_req_error;
                r_lo       <= 32'd0;
                r_hi       <= 32'd0;
            end
            if (r_state == S_ACC0 && !r_write) begin
                r_lo <= bus.mem_read_data;
            end
            if (r_state == S_ACC1 && !r_write) begin
                r_hi <= bus.mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a misaligned-capable unit on a small word memory and
// a strict unit on fixed read data, checked against a byte-level memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic mem_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  load_store_unit_if u_if1 ();
  load_store_unit_if u_if2 ();
  logic [1:0] dbg1;
  logic [1:0] dbg2;

  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(u_if1), .o_dbg_state(dbg1)
  );
  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .bus(u_if2), .o_dbg_state(dbg2)
  );

  // shared request drive, steered to one unit by sel
  logic        sel;
  logic        b_valid;
  logic        b_write;
  logic [1:0]  b_size;
  logic        b_uns;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;

  assign u_if1.req_valid      = b_valid & ~sel;
  assign u_if2.req_valid      = b_valid & sel;
  assign u_if1.req_write      = b_write;
  assign u_if2.req_write      = b_write;
  assign u_if1.req_size       = b_size;
  assign u_if2.req_size       = b_size;
  assign u_if1.req_unsigned   = b_uns;
  assign u_if2.req_unsigned   = b_uns;
  assign u_if1.req_address    = b_addr;
  assign u_if2.req_address    = b_addr;
  assign u_if1.req_write_data = b_wdata;
  assign u_if2.req_write_data = b_wdata;

  logic        v_ready;
  logic        v_resp_valid;
  logic [31:0] v_rdata;
  logic        v_err;
  logic [31:0] v_addr;
  logic [3:0]  v_be;
  logic [31:0] v_wd;
  logic [1:0]  v_dbg;

  assign v_ready      = sel ? u_if2.req_ready       : u_if1.req_ready;
  assign v_resp_valid = sel ? u_if2.resp_valid      : u_if1.resp_valid;
  assign v_rdata      = sel ? u_if2.resp_read_data  : u_if1.resp_read_data;
  assign v_err        = sel ? u_if2.resp_error      : u_if1.resp_error;
  assign v_addr       = sel ? u_if2.mem_address     : u_if1.mem_address;
  assign v_be         = sel ? u_if2.mem_byte_enable : u_if1.mem_byte_enable;
  assign v_wd         = sel ? u_if2.mem_write_data  : u_if1.mem_write_data;
  assign v_dbg        = sel ? dbg2 : dbg1;

  // ---------------- memories ----------------
  // unit 1: 256-word sync-write / comb-read memory (address bits [9:2])
  logic [31:0] mem [256];
  assign u_if1.mem_read_data = mem[u_if1.mem_address[9:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (u_if1.mem_byte_enable[l])
          mem[u_if1.mem_address[9:2]][8*l +: 8] <= u_if1.mem_write_data[8*l +: 8];
    end
  end
  // unit 2: fixed read data
  assign u_if2.mem_read_data = 32'h8000_0001;

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [1024];

  function automatic int ref_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic int ref_lat(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1;
    return (int'(a[1:0]) + ref_bytes(sz) > 4) ? 3 : 2;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [9:0] idx;
    for (int i = 0; i < ref_bytes(sz); i++) begin
      idx = a[9:0] + 10'(i);
      ref_mem[idx] = wd[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un, input logic [31:0] a);
    logic [31:0] v;
    logic [9:0]  idx;
    int          n;
    v = 32'd0;
    n = ref_bytes(sz);
    for (int i = 0; i < n; i++) begin
      idx = a[9:0] + 10'(i);
      v[8*i +: 8] = ref_mem[idx];
    end
    if (!un && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_err;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic [31:0] tr_addr [4];
  logic [3:0]  tr_be   [4];
  logic [31:0] tr_wd   [4];
  int          tr_n;

  task automatic do_req(input logic s, input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int   guard;
    logic got;
    rd = 32'd0; er = 1'b0; lat = 0; got = 1'b0; tr_n = 0;
    @(negedge clk);
    sel = s; b_write = wr; b_size = sz; b_uns = un; b_addr = a; b_wdata = wd; b_valid = 1'b1;
    guard = 0;
    while (!v_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (!v_ready) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: req_ready stayed 0");
      b_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 b_valid = 1'b0;
    if (!s && wr && sz != 2'd3) ref_store(sz, a, wd);
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      chk("ready_busy", 32'(v_ready), 32'd0);
      if (v_be != 4'd0 && tr_n < 4) begin
        tr_addr[tr_n] = v_addr; tr_be[tr_n] = v_be; tr_wd[tr_n] = v_wd;
        tr_n++;
      end
      if (v_resp_valid) begin
        got = 1'b1; rd = v_rdata; er = v_err; lat = c;
      end else begin
        @(posedge clk);
      end
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL resp_timeout: no resp_valid within 6 cycles");
    end else begin
      @(negedge clk);
      chk("resp_one_cycle", 32'(v_resp_valid), 32'd0);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] wd;

    n_checks = 0; n_err = 0;
    sel = 1'b0; b_valid = 1'b0; b_write = 1'b0; b_size = 2'd0; b_uns = 1'b0;
    b_addr = 32'd0; b_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
    rst = 1'b1; mem_clr = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",      32'(v_ready), 32'd0);
    chk("rst_resp_valid", 32'(v_resp_valid), 32'd0);
    chk("rst_resp_error", 32'(v_err), 32'd0);
    chk("rst_rdata",      v_rdata, 32'd0);
    chk("rst_mem_addr",   v_addr, 32'd0);
    chk("rst_be",         32'(v_be), 32'd0);
    chk("rst_wd",         v_wd, 32'd0);
    chk("rst_state",      32'(v_dbg), 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    #1 chk("post_rst_ready", 32'(v_ready), 32'd1);

    // directed table on the misaligned-capable unit
    vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'h0000_0000, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,         32'hFFFF_FFAB, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,         32'h0000_00AB, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,         32'hFFFF_ABAD, 1'b0, 2});
    vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1122_3344, 32'h0000_0000, 1'b0, 3});
    vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,         32'h1122_3344, 1'b0, 3});
    vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h3344_BEEF, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 32'h0000_0104, 32'h0,         32'h0000_0022, 1'b0, 2});
    vecs.push_back(vec_t'{1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h1234_BEEF, 32'h0000_0000, 1'b0, 3});
    vecs.push_back(vec_t'{1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0000_BEEF, 1'b0, 3});
    vecs.push_back(vec_t'{1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_BEEF, 1'b0, 3});
    vecs.push_back(vec_t'{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 1});
    vecs.push_back(vec_t'{1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
    vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b1, 32'h0000_03FF, 32'h0,         32'h0000_00EF, 1'b0, 2});

    foreach (vecs[i]) begin
      do_req(1'b0, vecs[i].wr, vecs[i].sz, vecs[i].un, vecs[i].a, vecs[i].wd, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_er));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].wr == 1'b0 || vecs[i].exp_er)
        chk($sformatf("vec%0d_no_writes", i), 32'(tr_n), 32'd0);
    end

    // store lane traces: aligned word, single byte, crossing word, wrapping half
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, rd, er, lat);
    chk("sw_al_n", 32'(tr_n), 32'd1);
    chk("sw_al_addr", tr_addr[0], 32'h0000_0100);
    chk("sw_al_be", 32'(tr_be[0]), 32'hF);
    chk("sw_al_wd", tr_wd[0], 32'hDEAD_BEEF);
    do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00AB, rd, er, lat);
    chk("sb_n", 32'(tr_n), 32'd1);
    chk("sb_be", 32'(tr_be[0]), 32'b1000);
    chk("sb_wd_lane3", 32'(tr_wd[0][31:24]), 32'hAB);
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1122_3344, rd, er, lat);
    chk("sw_x_n", 32'(tr_n), 32'd2);
    chk("sw_x_addr0", tr_addr[0], 32'h0000_0100);
    chk("sw_x_be0", 32'(tr_be[0]), 32'b1100);
    chk("sw_x_wd0", tr_wd[0], 32'h3344_0000);
    chk("sw_x_addr1", tr_addr[1], 32'h0000_0104);
    chk("sw_x_be1", 32'(tr_be[1]), 32'b0011);
    chk("sw_x_wd1", tr_wd[1], 32'h0000_1122);
    do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h1234_BEEF, rd, er, lat);
    chk("sh_wrap_n", 32'(tr_n), 32'd2);
    chk("sh_wrap_addr0", tr_addr[0], 32'hFFFF_FFFC);
    chk("sh_wrap_be0", 32'(tr_be[0]), 32'b1000);
    chk("sh_wrap_wd0", tr_wd[0], 32'hEF00_0000);
    chk("sh_wrap_addr1", tr_addr[1], 32'h0000_0000);
    chk("sh_wrap_be1", 32'(tr_be[1]), 32'b0001);
    chk("sh_wrap_wd1", tr_wd[1], 32'h0012_34BE);

    // strict unit: crossings rejected without memory activity
    do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0103, 32'h0, rd, er, lat);
    chk("strict_lh_err", 32'(er), 32'd1);
    chk("strict_lh_lat", 32'(lat), 32'd1);
    chk("strict_lh_rdata", rd, 32'd0);
    do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0101, 32'hFFFF_FFFF, rd, er, lat);
    chk("strict_sw_err", 32'(er), 32'd1);
    chk("strict_sw_no_writes", 32'(tr_n), 32'd0);
    do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, rd, er, lat);
    chk("strict_lh_ok_err", 32'(er), 32'd0);
    chk("strict_lh_ok_rdata", rd, 32'hFFFF_8000);
    chk("strict_lh_ok_lat", 32'(lat), 32'd2);
    do_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'h0, rd, er, lat);
    chk("strict_lbu_rdata", rd, 32'h0000_0001);

    // reset during the second access of a crossing store
    @(negedge clk);
    sel = 1'b0; b_write = 1'b1; b_size = 2'd2; b_uns = 1'b0;
    b_addr = 32'h0000_0202; b_wdata = 32'hCAFE_F00D; b_valid = 1'b1;
    chk("t6_ready", 32'(v_ready), 32'd1);
    @(posedge clk);
    #1 b_valid = 1'b0;
    @(negedge clk);
    chk("t6_acc0_be", 32'(v_be), 32'b1100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_be_in_rst", 32'(v_be), 32'd0);
    chk("t6_resp_in_rst", 32'(v_resp_valid), 32'd0);
    chk("t6_ready_in_rst", 32'(v_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_resp_after_edge", 32'(v_resp_valid), 32'd0);
    chk("t6_state_idle", 32'(v_dbg), 32'd0);
    rst = 1'b0;
    #1 chk("t6_ready_after", 32'(v_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_no_resp", 32'(v_resp_valid), 32'd0);
    end
    ref_mem[10'h202] = 8'h0D;
    ref_mem[10'h203] = 8'hF0;
    exp_q.push_back(ref_load(2'd2, 1'b0, 32'h0000_0200));
    exp_q.push_back(ref_load(2'd2, 1'b0, 32'h0000_0204));
    do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, rd, er, lat);
    chk("t6_word0", rd, exp_q.pop_front());
    do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'h0, rd, er, lat);
    chk("t6_word1", rd, exp_q.pop_front());

    // randomized traffic against the byte model
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      un = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) a = a | 32'hFFFF_FC00;
      wd = $urandom;
      exp_q.push_back((wr || sz == 2'd3) ? 32'd0 : ref_load(sz, un, a));
      do_req(1'b0, wr, sz, un, a, wd, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", n), rd, exp_q.pop_front());
      chk($sformatf("rnd%0d_error", n), 32'(er), 32'(sz == 2'd3));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(ref_lat(sz, a)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
